// File: rtl/aclk_pkg.sv
// aclk_pkg: shared key codes, scanner state encoding and keypad map for the alarm clock front end
package aclk_pkg;
  localparam logic [3:0] NOKEY = 4'd10;
  localparam logic [3:0] KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3, KEY_4 = 4'd4;
  localparam logic [3:0] KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7, KEY_8 = 4'd8, KEY_9 = 4'd9;
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} scan_state_t;
  // Rows 0-2 hold digits 1-9; row 3 is '*', 0, '#', and '*'/'#' decode as no key.
  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    return row == 2'd3 ? (col == 2'd1 ? KEY_0 : NOKEY) : 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
  endfunction
endpackage

// File: rtl/aclk_debounce.sv
// aclk_debounce: level debouncer; ports clock, reset (sync, active-low), tick (sample strobe), din (synchronized level), dout (debounced level)
module aclk_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    if (!reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (tick) begin
      if (din == dout) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        dout <= din;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/aclk_keypad_scanner.sv
// aclk_keypad_scanner: 4x3 keypad scanner + button debouncers; in clock, reset (sync active-low), col_n, alarm_raw, time_raw; out row_n, key, alarm_button, time_button
module aclk_keypad_scanner
  import aclk_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] col_n,
  input  logic       alarm_raw,
  input  logic       time_raw,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       alarm_button,
  output logic       time_button
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [2:0] col_s1, col_s2, low;
  logic [1:0] alarm_s, time_s, row, row_nx, col;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] cand, cand_nx, key_nx, code;
  logic tick, valid, last;
  scan_state_t state, state_nx;
  always_ff @(posedge clock)
    if (!reset) begin
      col_s1  <= '1;
      col_s2  <= '1;
      alarm_s <= '0;
      time_s  <= '0;
      div     <= '0;
    end else begin
      col_s1  <= col_n;
      col_s2  <= col_s1;
      alarm_s <= {alarm_s[0], alarm_raw};
      time_s  <= {time_s[0], time_raw};
      div     <= tick ? '0 : div + 1'b1;
    end
  assign tick  = div == DW'(SCAN_DIV - 1);
  assign low   = ~col_s2;
  assign col   = low[0] ? 2'd0 : low[1] ? 2'd1 : 2'd2;
  assign code  = key_at(row, col);
  assign valid = (low == 3'b001 || low == 3'b010 || low == 3'b100) && code != NOKEY;
  // cnt holds matches seen so far, so the next agreeing sample is the accepting one
  assign last  = cnt == CW'(DEBOUNCE - 1);
  always_comb begin
    state_nx = state;
    row_nx   = row;
    cnt_nx   = cnt;
    cand_nx  = cand;
    key_nx   = key;
    if (tick)
      case (state)
        ST_SCAN:
          if (valid) begin
            cand_nx  = code;
            cnt_nx   = CW'(1);
            state_nx = DEBOUNCE == 1 ? ST_PRESSED : ST_DEBOUNCE;
            key_nx   = DEBOUNCE == 1 ? code : key;
          end else row_nx = row + 1'b1;
        ST_DEBOUNCE:
          if (valid && code == cand) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = last ? ST_PRESSED : ST_DEBOUNCE;
            key_nx   = last ? cand : key;
          end else begin
            state_nx = ST_SCAN;
            row_nx   = row + 1'b1;
          end
        ST_PRESSED:
          if (!valid) begin
            cnt_nx   = CW'(1);
            state_nx = DEBOUNCE == 1 ? ST_SCAN : ST_RELEASE;
            key_nx   = DEBOUNCE == 1 ? NOKEY : key;
            row_nx   = DEBOUNCE == 1 ? row + 1'b1 : row;
          end
        ST_RELEASE:
          if (!valid) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = last ? ST_SCAN : ST_RELEASE;
            key_nx   = last ? NOKEY : key;
            row_nx   = last ? row + 1'b1 : row;
          end else if (code == key) begin
            cnt_nx   = '0;
            state_nx = ST_PRESSED;
          end
        default: state_nx = ST_SCAN;
      endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state <= ST_SCAN;
      row   <= '0;
      cnt   <= '0;
      cand  <= NOKEY;
      key   <= NOKEY;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
      key   <= key_nx;
    end
  assign row_n = ~(4'b0001 << row);
  aclk_debounce #(.DEBOUNCE(DEBOUNCE)) u_alarm (.clock(clock), .reset(reset), .tick(tick), .din(alarm_s[1]), .dout(alarm_button));
  aclk_debounce #(.DEBOUNCE(DEBOUNCE)) u_time (.clock(clock), .reset(reset), .tick(tick), .din(time_s[1]), .dout(time_button));
endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// tb_aclk_keypad_scanner: randomized keypad/button stimulus with an event scoreboard for key, alarm_button and time_button
module tb_aclk_keypad_scanner;
  logic clock = 1'b0, reset = 1'b0, alarm_raw = 1'b0, time_raw = 1'b0;
  logic [2:0] col_n;
  logic [3:0] row_n, key;
  logic alarm_button, time_button;
  logic pressed[12];
  int tests = 0, fails = 0;
  logic [3:0] kq[$];
  logic aq[$], tq[$];
  logic mon_en = 1'b0;
  logic [3:0] pk = 4'd10;
  logic pa = 1'b0, pt = 1'b0;
  always #5 clock = ~clock;
  aclk_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock(clock), .reset(reset), .col_n(col_n), .alarm_raw(alarm_raw), .time_raw(time_raw),
    .row_n(row_n), .key(key), .alarm_button(alarm_button), .time_button(time_button)
  );
  // keypad: a pressed switch at position r*3+c ties column c to row r when that row is driven low
  always_comb begin
    col_n = 3'b111;
    for (int i = 0; i < 12; i++) if (pressed[i] && !row_n[i/3]) col_n[i%3] = 1'b0;
  end
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  always @(negedge clock) if (mon_en) begin
    if (key !== pk) begin
      if (kq.size() == 0) begin
        tests++; fails++;
        $display("FAIL key_unexpected: got %0d, required no change from %0d", key, pk);
      end else check("key_event", key, kq.pop_front());
      pk = key;
    end
    if (alarm_button !== pa) begin
      if (aq.size() == 0) begin
        tests++; fails++;
        $display("FAIL alarm_unexpected: got %0d, required no change", alarm_button);
      end else check("alarm_event", {3'b0, alarm_button}, {3'b0, aq.pop_front()});
      pa = alarm_button;
    end
    if (time_button !== pt) begin
      if (tq.size() == 0) begin
        tests++; fails++;
        $display("FAIL time_unexpected: got %0d, required no change", time_button);
      end else check("time_event", {3'b0, time_button}, {3'b0, tq.pop_front()});
      pt = time_button;
    end
  end
  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  function automatic int pos_of(input int d);
    return d == 0 ? 10 : d - 1;
  endfunction
  task automatic wait_row3();
    logic [3:0] prev;
    prev = row_n;
    for (int t = 0; t < 200; t++) begin
      @(posedge clock);
      #1;
      if (row_n == 4'b0111 && prev != 4'b0111) return;
      prev = row_n;
    end
    tests++; fails++;
    $display("FAIL row3_wait: row_n=%b, required entry into row 3 within 200 clocks", row_n);
  endtask
  task automatic button_pulse(input bit which);
    int n, w;
    n = $urandom_range(1, 5);
    w = $urandom_range(0, 10);
    clk(w);
    // a level held 4n clocks is seen by exactly n ticks; 3 agreeing ticks flip the output
    if (n >= 3) begin
      if (which) begin tq.push_back(1'b1); tq.push_back(1'b0); end
      else begin aq.push_back(1'b1); aq.push_back(1'b0); end
    end
    if (which) time_raw = 1'b1; else alarm_raw = 1'b1;
    clk(4 * n);
    if (which) time_raw = 1'b0; else alarm_raw = 1'b0;
    clk(30);
  endtask
  task automatic scenario(input int sc);
    int d, r1, r2, c1, c2, p;
    case (sc)
      0: begin
        d = $urandom_range(0, 9);
        kq.push_back(4'(d));
        pressed[pos_of(d)] = 1'b1;
        clk($urandom_range(40, 80));
        kq.push_back(4'd10);
        pressed[pos_of(d)] = 1'b0;
        clk(40);
      end
      1: begin
        p = $urandom_range(0, 1) ? 9 : 11;
        pressed[p] = 1'b1;
        clk(60);
        check("star_hash", key, 4'd10);
        pressed[p] = 1'b0;
        clk(20);
      end
      2: begin
        r1 = $urandom_range(0, 2);
        c1 = $urandom_range(0, 2);
        c2 = (c1 + $urandom_range(1, 2)) % 3;
        pressed[r1*3+c1] = 1'b1;
        pressed[r1*3+c2] = 1'b1;
        clk(60);
        check("same_row_pair", key, 4'd10);
        pressed[r1*3+c1] = 1'b0;
        pressed[r1*3+c2] = 1'b0;
        clk(20);
      end
      3: begin
        r1 = $urandom_range(0, 1);
        r2 = $urandom_range(r1 + 1, 2);
        c1 = $urandom_range(0, 2);
        c2 = $urandom_range(0, 2);
        wait_row3();
        kq.push_back(4'(r1 * 3 + c1 + 1));
        pressed[r1*3+c1] = 1'b1;
        pressed[r2*3+c2] = 1'b1;
        clk(60);
        kq.push_back(4'd10);
        pressed[r1*3+c1] = 1'b0;
        pressed[r2*3+c2] = 1'b0;
        clk(40);
      end
      default: begin
        d = $urandom_range(0, 9);
        kq.push_back(4'(d));
        pressed[pos_of(d)] = 1'b1;
        clk(50);
        pressed[pos_of(d)] = 1'b0;
        clk(4);
        pressed[pos_of(d)] = 1'b1;
        clk(40);
        check("release_glitch", key, 4'(d));
        kq.push_back(4'd10);
        pressed[pos_of(d)] = 1'b0;
        clk(40);
      end
    endcase
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 12; i++) pressed[i] = 1'b0;
    clk(3);
    check("reset_key", key, 4'd10);
    check("reset_row", row_n, 4'b1110);
    check("reset_alarm", {3'b0, alarm_button}, 4'd0);
    check("reset_time", {3'b0, time_button}, 4'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    wait_row3();
    kq.push_back(4'd6);
    pressed[5] = 1'b1;
    clk(19);
    check("press_before_latency", key, 4'd10);
    clk(1);
    check("press_latency", key, 4'd6);
    check("row_frozen_a", row_n, 4'b1101);
    clk(20);
    check("row_frozen_b", row_n, 4'b1101);
    kq.push_back(4'd10);
    pressed[5] = 1'b0;
    clk(40);
    check("released", key, 4'd10);
    pressed[10] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clk(3);
      pressed[10] = !pressed[10];
    end
    clk(2);
    check("bounce_hold", key, 4'd10);
    kq.push_back(4'd0);
    clk(40);
    check("bounce_settled", key, 4'd0);
    kq.push_back(4'd10);
    pressed[10] = 1'b0;
    clk(40);
    for (int it = 0; it < 16; it++) begin
      int sc;
      sc = $urandom_range(0, 4);
      fork
        button_pulse(1'b0);
        button_pulse(1'b1);
        scenario(sc);
      join
    end
    kq.push_back(4'd5);
    pressed[4] = 1'b1;
    clk(50);
    check("pre_reset_key", key, 4'd5);
    kq.push_back(4'd10);
    kq.push_back(4'd5);
    reset = 1'b0;
    clk(1);
    check("mid_reset_key", key, 4'd10);
    check("mid_reset_row", row_n, 4'b1110);
    check("mid_reset_alarm", {3'b0, alarm_button}, 4'd0);
    check("mid_reset_time", {3'b0, time_button}, 4'd0);
    reset = 1'b1;
    clk(4);
    check("restart_row1", row_n, 4'b1101);
    clk(40);
    kq.push_back(4'd10);
    pressed[4] = 1'b0;
    clk(40);
    tests++;
    if (kq.size() != 0 || aq.size() != 0 || tq.size() != 0) begin
      fails++;
      $display("FAIL pending_events: key %0d alarm %0d time %0d left, required 0 0 0", kq.size(), aq.size(), tq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
